// File: rtl/numlock_pkg.sv
// Shared types and helpers for the parametrised U/Z number lock.
package numlock_pkg;

    localparam int IDX_INIT    = 0;
    localparam int IDX_GET     = 1;
    localparam int IDX_WAIT    = 2;
    localparam int IDX_OPENING = 3;
    localparam int IDX_BAD     = 4;
    localparam int IDX_LOCKOUT = 5;

    typedef enum logic [5:0] {
        S_INIT    = 6'b000001,
        S_GET     = 6'b000010,
        S_WAIT    = 6'b000100,
        S_OPENING = 6'b001000,
        S_BAD     = 6'b010000,
        S_LOCKOUT = 6'b100000
    } state_t;

    // Digit expected at position idx, MSB of the code entered first; 1 = U, 0 = Z.
    function automatic logic expected_digit(input logic [31:0] code, input int len, input int idx);
        logic [31:0] sh;
        sh = 32'd0;
        if ((idx >= 0) && (idx < len)) begin
            sh = code >> (len - 1 - idx);
        end else begin
            sh = 32'd0;
        end
        return sh[0];
    endfunction

endpackage

// File: rtl/numlock_timer.sv
// Loadable down-counter shared by the two timed states (OPENING and LOCKOUT).
module numlock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] value,
    output logic         done
);

    logic [W-1:0] value_q;

    // Count register: load wins over decrement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_val;
        end else if (en) begin
            value_q <= value_q - W'(1);
        end else begin
            value_q <= value_q;
        end
    end

    assign value = value_q;
    assign done  = (value_q == '0);

endmodule

// File: rtl/numlock_param_sm.sv
// Number-lock controller: parametrised U/Z code, failed-attempt lockout, timed opening.
module numlock_param_sm
    import numlock_pkg::*;
#(
    parameter int                  CODE_LEN       = 4,
    parameter logic [CODE_LEN-1:0] CODE           = 4'b1011,
    parameter int                  OPEN_CYCLES    = 16,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  LOCKOUT_CYCLES = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             U,
    input  logic                             Z,
    output logic                             q_I,
    output logic                             q_Get,
    output logic                             q_Wait,
    output logic                             q_Opening,
    output logic                             q_Bad,
    output logic                             q_Lockout,
    output logic                             Unlock,
    output logic [$clog2(CODE_LEN+1)-1:0]    digit_idx,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_cnt
);

    localparam int DW   = $clog2(CODE_LEN + 1);
    localparam int FW   = $clog2(MAX_FAILS + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

    localparam logic [DW-1:0] LEN_V   = DW'(CODE_LEN);
    localparam logic [FW-1:0] MAXF_V  = FW'(MAX_FAILS);
    localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LD = TW'(LOCKOUT_CYCLES - 1);

    state_t          state_q, state_d;
    logic [DW-1:0]   digit_idx_q, digit_idx_d;
    logic [FW-1:0]   fail_cnt_q, fail_cnt_d;

    logic            idle_s;
    logic            exp_digit_s;
    logic            digit_ok_s;
    logic            tmr_load_s;
    logic [TW-1:0]   tmr_load_val_s;
    logic            tmr_en_s;
    logic [TW-1:0]   tmr_value_s;
    logic            tmr_done_s;

    assign idle_s      = ~U & ~Z;
    assign exp_digit_s = expected_digit(32'(CODE), CODE_LEN, int'(digit_idx_q));
    assign digit_ok_s  = exp_digit_s ? (U & ~Z) : (Z & ~U);
    assign tmr_en_s    = (state_q[IDX_OPENING] | state_q[IDX_LOCKOUT]) & (tmr_value_s != '0);

    numlock_timer #(
        .W (TW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_load_val_s),
        .en       (tmr_en_s),
        .value    (tmr_value_s),
        .done     (tmr_done_s)
    );

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_INIT;
            digit_idx_q <= '0;
            fail_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            digit_idx_q <= digit_idx_d;
            fail_cnt_q  <= fail_cnt_d;
        end
    end

    // Next-state, counter updates and timer loads.
    always_comb begin
        state_d        = state_q;
        digit_idx_d    = digit_idx_q;
        fail_cnt_d     = fail_cnt_q;
        tmr_load_s     = 1'b0;
        tmr_load_val_s = '0;
        case (state_q)
            S_INIT: begin
                if (digit_ok_s) begin
                    state_d     = S_GET;
                    digit_idx_d = DW'(1);
                end else begin
                    state_d = S_INIT;
                end
            end
            S_GET: begin
                if (!idle_s) begin
                    state_d = S_GET;
                end else if (digit_idx_q == LEN_V) begin
                    state_d        = S_OPENING;
                    digit_idx_d    = '0;
                    fail_cnt_d     = '0;
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = OPEN_LD;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (idle_s) begin
                    state_d = S_WAIT;
                end else if (digit_ok_s) begin
                    state_d     = S_GET;
                    digit_idx_d = digit_idx_q + DW'(1);
                end else begin
                    state_d     = S_BAD;
                    digit_idx_d = '0;
                    fail_cnt_d  = (fail_cnt_q == MAXF_V) ? fail_cnt_q : fail_cnt_q + FW'(1);
                end
            end
            S_BAD: begin
                if (!idle_s) begin
                    state_d = S_BAD;
                end else if (fail_cnt_q == MAXF_V) begin
                    state_d        = S_LOCKOUT;
                    tmr_load_s     = 1'b1;
                    tmr_load_val_s = LOCK_LD;
                end else begin
                    state_d = S_INIT;
                end
            end
            S_OPENING: begin
                if (tmr_done_s) begin
                    state_d = S_INIT;
                end else begin
                    state_d = S_OPENING;
                end
            end
            S_LOCKOUT: begin
                if (tmr_done_s) begin
                    state_d    = S_INIT;
                    fail_cnt_d = '0;
                end else begin
                    state_d = S_LOCKOUT;
                end
            end
            default: begin
                state_d     = S_INIT;
                digit_idx_d = '0;
                fail_cnt_d  = '0;
            end
        endcase
    end

    assign q_I       = state_q[IDX_INIT];
    assign q_Get     = state_q[IDX_GET];
    assign q_Wait    = state_q[IDX_WAIT];
    assign q_Opening = state_q[IDX_OPENING];
    assign q_Bad     = state_q[IDX_BAD];
    assign q_Lockout = state_q[IDX_LOCKOUT];
    assign Unlock    = state_q[IDX_OPENING];
    assign digit_idx = digit_idx_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_numlock_param_sm.sv
// Bench for numlock_param_sm: default instance plus a one-digit, short-open variant.
module tb_numlock_param_sm;

    localparam logic [5:0] ST_I    = 6'b000001;
    localparam logic [5:0] ST_GET  = 6'b000010;
    localparam logic [5:0] ST_WAIT = 6'b000100;
    localparam logic [5:0] ST_OPEN = 6'b001000;
    localparam logic [5:0] ST_BAD  = 6'b010000;
    localparam logic [5:0] ST_LOCK = 6'b100000;

    typedef struct packed {
        logic [5:0] st;
        logic [2:0] idx;
        logic [1:0] fail;
    } exp_t;

    typedef struct {
        string      nm;
        logic       u;
        logic       z;
        logic [5:0] st;
        int         idx;
        int         fail;
    } vec_t;

    logic clk = 1'b0;
    logic rst0, rst1, U, Z;

    logic       d0_i, d0_get, d0_wait, d0_open, d0_bad, d0_lock, d0_unlock;
    logic [2:0] d0_idx;
    logic [1:0] d0_fail;
    logic       d1_i, d1_get, d1_wait, d1_open, d1_bad, d1_lock, d1_unlock;
    logic [0:0] d1_idx;
    logic [1:0] d1_fail;

    int   checks = 0;
    int   errors = 0;
    int   sel    = 0;
    exp_t sb_q[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    numlock_param_sm dut0 (
        .clk(clk), .reset(rst0), .U(U), .Z(Z),
        .q_I(d0_i), .q_Get(d0_get), .q_Wait(d0_wait), .q_Opening(d0_open),
        .q_Bad(d0_bad), .q_Lockout(d0_lock), .Unlock(d0_unlock),
        .digit_idx(d0_idx), .fail_cnt(d0_fail)
    );

    numlock_param_sm #(
        .CODE_LEN(1), .CODE(1'b0), .OPEN_CYCLES(3)
    ) dut1 (
        .clk(clk), .reset(rst1), .U(U), .Z(Z),
        .q_I(d1_i), .q_Get(d1_get), .q_Wait(d1_wait), .q_Opening(d1_open),
        .q_Bad(d1_bad), .q_Lockout(d1_lock), .Unlock(d1_unlock),
        .digit_idx(d1_idx), .fail_cnt(d1_fail)
    );

    function automatic exp_t mk(input logic [5:0] st, input int idx, input int fl);
        exp_t e;
        e.st   = st;
        e.idx  = 3'(idx);
        e.fail = 2'(fl);
        return e;
    endfunction

    task automatic check_out(input string nm);
        exp_t       e;
        logic [5:0] st;
        logic       unl;
        logic [2:0] idx;
        logic [1:0] fl;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb_q.pop_front();
            if (sel == 0) begin
                st  = {d0_lock, d0_bad, d0_open, d0_wait, d0_get, d0_i};
                unl = d0_unlock;
                idx = d0_idx;
                fl  = d0_fail;
            end else begin
                st  = {d1_lock, d1_bad, d1_open, d1_wait, d1_get, d1_i};
                unl = d1_unlock;
                idx = {2'b00, d1_idx};
                fl  = d1_fail;
            end
            if (st !== e.st || unl !== e.st[3] || idx !== e.idx || fl !== e.fail) begin
                errors++;
                $display("FAIL %s: got st=%b unlock=%b idx=%0d fail=%0d, want st=%b unlock=%b idx=%0d fail=%0d",
                         nm, st, unl, idx, fl, e.st, e.st[3], e.idx, e.fail);
            end
        end
    endtask

    task automatic step(input string nm, input logic u, input logic z,
                        input logic [5:0] st, input int idx, input int fl);
        U = u;
        Z = z;
        sb_q.push_back(mk(st, idx, fl));
        @(posedge clk);
        #1;
        check_out(nm);
    endtask

    initial begin
        tbl[0] = '{"code_u1",   1'b1, 1'b0, ST_GET,  1, 0};
        tbl[1] = '{"code_rel1", 1'b0, 1'b0, ST_WAIT, 1, 0};
        tbl[2] = '{"code_z2",   1'b0, 1'b1, ST_GET,  2, 0};
        tbl[3] = '{"code_rel2", 1'b0, 1'b0, ST_WAIT, 2, 0};
        tbl[4] = '{"code_u3",   1'b1, 1'b0, ST_GET,  3, 0};
        tbl[5] = '{"code_rel3", 1'b0, 1'b0, ST_WAIT, 3, 0};
        tbl[6] = '{"code_u4",   1'b1, 1'b0, ST_GET,  4, 0};
        tbl[7] = '{"code_open", 1'b0, 1'b0, ST_OPEN, 0, 0};

        rst0 = 1'b1;
        rst1 = 1'b1;
        U    = 1'b0;
        Z    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;
        sb_q.push_back(mk(ST_I, 0, 0));
        check_out("reset_state");

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].nm, tbl[i].u, tbl[i].z, tbl[i].st, tbl[i].idx, tbl[i].fail);
        end
        for (int k = 1; k < 16; k++) step("open_hold", 1'b0, 1'b0, ST_OPEN, 0, 0);
        step("open_exit", 1'b0, 1'b0, ST_I, 0, 0);

        // Three wrong attempts; the third release enters lockout.
        for (int a = 1; a <= 3; a++) begin
            step("bad_u1",  1'b1, 1'b0, ST_GET,  1, a - 1);
            step("bad_rel", 1'b0, 1'b0, ST_WAIT, 1, a - 1);
            step("bad_u2",  1'b1, 1'b0, ST_BAD,  0, a);
            if (a == 1) step("bad_held", 1'b1, 1'b0, ST_BAD, 0, a);
            step("bad_exit", 1'b0, 1'b0, (a == 3) ? ST_LOCK : ST_I, 0, a);
        end
        for (int k = 1; k < 64; k++) step("lock_hold", 1'(k % 2), 1'(~k % 2), ST_LOCK, 0, 3);
        step("lock_exit", 1'b0, 1'b0, ST_I, 0, 0);

        // Final digit held: opening waits for release.
        step("hold_u1",  1'b1, 1'b0, ST_GET,  1, 0);
        step("hold_r1",  1'b0, 1'b0, ST_WAIT, 1, 0);
        step("hold_z2",  1'b0, 1'b1, ST_GET,  2, 0);
        step("hold_r2",  1'b0, 1'b0, ST_WAIT, 2, 0);
        step("hold_u3",  1'b1, 1'b0, ST_GET,  3, 0);
        step("hold_r3",  1'b0, 1'b0, ST_WAIT, 3, 0);
        for (int k = 0; k < 6; k++) step("hold_last", 1'b1, 1'b0, ST_GET, 4, 0);
        step("hold_open", 1'b0, 1'b0, ST_OPEN, 0, 0);
        for (int k = 1; k < 16; k++) step("hold_open_on", 1'b0, 1'b0, ST_OPEN, 0, 0);
        step("hold_open_exit", 1'b0, 1'b0, ST_I, 0, 0);

        step("init_z",    1'b0, 1'b1, ST_I,    0, 0);
        step("init_uz",   1'b1, 1'b1, ST_I,    0, 0);
        step("ill_u1",    1'b1, 1'b0, ST_GET,  1, 0);
        step("ill_r1",    1'b0, 1'b0, ST_WAIT, 1, 0);
        step("ill_z2",    1'b0, 1'b1, ST_GET,  2, 0);
        step("ill_r2",    1'b0, 1'b0, ST_WAIT, 2, 0);
        step("wait_uz",   1'b1, 1'b1, ST_BAD,  0, 1);
        step("wait_uz_r", 1'b0, 1'b0, ST_I,    0, 1);
        step("get_u",     1'b1, 1'b0, ST_GET,  1, 1);
        for (int k = 0; k < 20; k++) step("get_held", 1'b1, 1'b0, ST_GET, 1, 1);
        step("get_rel",   1'b0, 1'b0, ST_WAIT, 1, 1);

        // Asynchronous reset between edges.
        @(negedge clk);
        rst0 = 1'b1;
        #1;
        sb_q.push_back(mk(ST_I, 0, 0));
        check_out("async_reset");
        @(negedge clk);
        rst0 = 1'b0;
        step("post_reset", 1'b1, 1'b0, ST_GET, 1, 0);
        step("post_rel",   1'b0, 1'b0, ST_WAIT, 1, 0);

        // One-digit variant: CODE=0, OPEN_CYCLES=3.
        rst0 = 1'b1;
        sel  = 1;
        @(negedge clk);
        rst1 = 1'b0;
        step("v_z",     1'b0, 1'b1, ST_GET,  1, 0);
        step("v_open",  1'b0, 1'b0, ST_OPEN, 0, 0);
        step("v_open2", 1'b0, 1'b0, ST_OPEN, 0, 0);
        step("v_open3", 1'b0, 1'b0, ST_OPEN, 0, 0);
        step("v_exit",  1'b0, 1'b0, ST_I,    0, 0);
        step("v_u_ign", 1'b1, 1'b0, ST_I,    0, 0);
        step("v_z2",    1'b0, 1'b1, ST_GET,  1, 0);
        step("v_open_b", 1'b0, 1'b0, ST_OPEN, 0, 0);
        @(negedge clk);
        rst1 = 1'b1;
        #1;
        sb_q.push_back(mk(ST_I, 0, 0));
        check_out("v_async_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/numlock_param_sm.md
# numlock_param_sm

Parametrised number-lock controller: the next generation of the course's fixed-code U/Z number lock. The unlock code length and bit pattern are parameters. A failed-attempt counter triggers a timed lockout, and the Opening interval is a parameter. It sits between debounced, synchronised U/Z push-button levels and the door-latch/LED outputs on the board top level.

## Interface

- CODE_LEN, 4, number of code digits (1..32)
- CODE, 4'b1011, code pattern, MSB entered first; 1 = U press, 0 = Z press
- OPEN_CYCLES, 16, clocks Unlock stays high (>=1)
- MAX_FAILS, 3, consecutive Bad entries that trigger lockout (>=1)
- LOCKOUT_CYCLES, 64, clocks spent in Lockout (>=1)

- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- U  in  1  "1" button level, debounced and synchronised
- Z  in  1  "0" button level, debounced and synchronised
- q_I, q_Get, q_Wait, q_Opening, q_Bad, q_Lockout  out  1 each  one-hot state flags
- Unlock  out  1  equals q_Opening
- digit_idx  out  $clog2(CODE_LEN+1)  correct digits accepted in current attempt
- fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failures, saturating at MAX_FAILS

## Operation

- Press = exactly one of U/Z high. Both high = illegal. Idle = both low.
- Digit expected at index i is CODE[CODE_LEN-1-i].
- INIT:
  - correct first digit pressed → GET, digit_idx=1.
  - any other input, including wrong digit or U&Z, is ignored; stay in INIT.
- GET:
  - U/Z changes are ignored until idle.
  - on idle: if digit_idx==CODE_LEN → OPENING, else → WAIT.
- WAIT:
  - idle → stay.
  - correct digit → GET, digit_idx+1.
  - wrong digit or U&Z → BAD.
- BAD:
  - entry increments fail_cnt (saturating); digit_idx is cleared.
  - stays until idle; on idle → LOCKOUT if fail_cnt==MAX_FAILS, else INIT.
- OPENING:
  - Unlock=1; fail_cnt and digit_idx cleared on entry.
  - inputs ignored; → INIT after OPEN_CYCLES clocks.
- LOCKOUT:
  - inputs ignored; → INIT after LOCKOUT_CYCLES clocks.
  - fail_cnt cleared on exit.
- All outputs are Moore: registered state plus registered counters, no combinational path from U/Z.

## Timing

- Reset value:
  - q_I=1; all other q_* = 0.
  - Unlock=0, digit_idx=0, fail_cnt=0, timer=0.
  - Outputs take reset values immediately, without waiting for a clock edge.
- Reset during OPENING/LOCKOUT drops Unlock/q_Lockout asynchronously. The attempt is abandoned and fail_cnt is cleared.
- Input sampled at edge k produces the state change visible after edge k (1-cycle latency).
- Timer:
  - loaded with N-1 on the entry edge; decrements each clock in the timed state.
  - at 0 the state exits on the next edge.
  - The timed state lasts exactly N cycles. Unlock is high exactly OPEN_CYCLES cycles.
- Timer width: $clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)), minimum 1.
- CODE_LEN=1: INIT → GET → (idle) → OPENING, with no WAIT visit.
- Holding the final digit delays OPENING until release, with no limit.
- Held buttons never generate repeated digits; one press = one digit.

## Structure

- Package numlock_pkg holds:
  - state_t enum: S_INIT, S_GET, S_WAIT, S_OPENING, S_BAD, S_LOCKOUT, one-hot 6-bit encoding
  - state-index constants
  - function expected_digit(code, len, idx)
- Sub-module numlock_timer: loadable down-counter with load, en, value and done (value==0). Parameter W.
  - A single instance is shared by OPENING and LOCKOUT, since the two are mutually exclusive.
- The top module contains the state register, next-state logic, digit_idx and fail_cnt registers.

## Test plan

- Reset: assert reset between edges → q_I=1, Unlock=0, digit_idx=0, fail_cnt=0 before the next clk edge.
- Correct code (defaults): U, release, Z, release, U, release, U, release. Expect:
  - digit_idx steps 1,2,3,4.
  - q_Opening/Unlock high exactly 16 cycles, then q_I=1, fail_cnt=0.
- Wrong digit: U, release, U → q_Bad one edge after the second U, fail_cnt=1, digit_idx=0. Release → q_I.
- Lockout: three wrong attempts → q_Lockout=1 after the third release for exactly 64 cycles, with U/Z toggling ignored. Then q_I=1, fail_cnt=0.
- Illegal/idle inputs:
  - Z alone or U&Z in INIT → stay q_I.
  - U&Z in WAIT (digit_idx=2) → q_Bad, fail_cnt=1.
  - Holding U across 20 cycles in GET → no digit_idx change.
- Parameter variant CODE_LEN=1, CODE=1'b0, OPEN_CYCLES=3:
  - Z press/release → Unlock high exactly 3 cycles.
  - Async reset asserted during OPENING → Unlock=0 immediately.
